// File: rtl/mem_checker_pkg.sv
// -----------------------------------------------------------------------------
// mem_checker_pkg
//   Shared definitions for the memory result checker:
//     state_t        - checker FSM states (also exported on the debug port)
//     BEGIN_SYM_DEF  - default start-of-test marker value
//     END_SYM_DEF    - default end-of-test marker value (last golden entry)
//     IDX_W          - width of golden-table indices
//     byte_swap()    - reverses the 8 bytes of a 64-bit word
// -----------------------------------------------------------------------------
package mem_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [31:0] BEGIN_SYM_DEF = 32'h0000_0168;
  localparam logic [31:0] END_SYM_DEF   = 32'hFFFF_FD5D;
  localparam int          IDX_W         = 10;

  // Full 64-bit byte reversal. Narrower words are left-aligned before the call
  // so their bytes land reversed in the low end of the result.
  function automatic logic [63:0] byte_swap(input logic [63:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24],
            d[39:32], d[47:40], d[55:48], d[63:56]};
  endfunction

endpackage

// File: rtl/checker_golden_ram.sv
// -----------------------------------------------------------------------------
// checker_golden_ram
//   Golden-value table, DEPTH x DATA_W. One synchronous write port and one
//   asynchronous read port. Contents are deliberately not reset so a table
//   loaded once survives checker resets.
//   Ports:
//     clk   - write clock
//     wen   - write enable (writes with widx >= DEPTH are dropped)
//     widx  - write index
//     wdata - write data
//     ridx  - read index (reads with ridx >= DEPTH return 0)
//     rdata - combinational read data
// -----------------------------------------------------------------------------
module checker_golden_ram #(
  parameter int DEPTH  = 31,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen && (widx < IDX_W'(DEPTH))) begin
      mem[widx[AW-1:0]] <= wdata;
    end
  end

  assign rdata = (ridx < IDX_W'(DEPTH)) ? mem[ridx[AW-1:0]] : '0;

endmodule

// File: rtl/mem_result_checker.sv
// -----------------------------------------------------------------------------
// mem_result_checker
//   Watches writes to one memory word (TEST_PORT). A BEGIN_SYM write starts a
//   run; the following NUM_CHECK writes are compared against a golden table.
//   The run ends after the last result word or after TIMEOUT_CYC cycles.
//   Ports:
//     clk, rst                  - clock, asynchronous active-low reset
//     addr, data, wen           - monitored memory write bus
//     gld_wen, gld_idx, gld_data- golden table load port (IDLE/REPORT only)
//     error_num                 - mismatch count, all-ones before first run,
//                                 saturates at 2^ERR_W-2
//     duration                  - cycles spent in CHECK during the last run
//     finish                    - run complete (held in REPORT)
//     timeout                   - run ended by the cycle limit
//     first_err_idx             - index of first mismatch, all-ones if none
//     state_dbg                 - current FSM state
// -----------------------------------------------------------------------------
module mem_result_checker
  import mem_checker_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 30,
  parameter logic [ADDR_W-1:0] TEST_PORT   = 'h3FF,
  parameter logic [DATA_W-1:0] BEGIN_SYM   = DATA_W'(BEGIN_SYM_DEF),
  parameter int                NUM_CHECK   = 31,
  parameter int                BYTE_SWAP   = 1,
  parameter int                TIMEOUT_CYC = 16'hFFFF,
  parameter int                ERR_W       = 8,
  parameter int                DUR_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  input  logic              gld_wen,
  input  logic [IDX_W-1:0]  gld_idx,
  input  logic [DATA_W-1:0] gld_data,
  output logic [ERR_W-1:0]  error_num,
  output logic [DUR_W-1:0]  duration,
  output logic              finish,
  output logic              timeout,
  output logic [IDX_W-1:0]  first_err_idx,
  output state_t            state_dbg
);

  localparam logic [ERR_W-1:0] ERR_SAT  = ~ERR_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECK - 1);
  localparam logic [DUR_W-1:0] TO_LAST  = DUR_W'(TIMEOUT_CYC - 1);

  state_t            state, state_nxt;
  logic              prev_wen;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] sdata;
  logic [DATA_W-1:0] gold;
  logic              accepted, is_begin, mismatch;
  logic              start, done, to_hit;

  // Write acceptance: a write counts on the first cycle wen is seen high at
  // TEST_PORT; wen must have been low the cycle before, so a held wen is a
  // single write. There is no back-pressure: the bus is only observed.
  assign accepted = wen && !prev_wen && (addr == TEST_PORT);

  // Left-align data in 64 bits so the full reversal lands it in the low bytes.
  assign sdata    = (BYTE_SWAP != 0) ? DATA_W'(byte_swap(64'(data) << (64 - DATA_W)))
                                     : data;
  assign is_begin = (sdata == BEGIN_SYM);
  assign mismatch = (sdata != gold);

  checker_golden_ram #(
    .DEPTH  (NUM_CHECK),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_golden (
    .clk   (clk),
    .wen   (gld_wen && (state != ST_CHECK)),
    .widx  (gld_idx),
    .wdata (gld_data),
    .ridx  (idx),
    .rdata (gold)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    to_hit    = 1'b0;
    unique case (state)
      ST_IDLE, ST_REPORT: begin
        if (accepted && is_begin) begin
          state_nxt = ST_CHECK;
          start     = 1'b1;
        end
      end
      ST_CHECK: begin
        to_hit = (duration == TO_LAST);
        if (to_hit || (accepted && (idx == LAST_IDX))) begin
          state_nxt = ST_REPORT;
          done      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_wen      <= 1'b0;
      error_num     <= '1;
      duration      <= '0;
      idx           <= '0;
      finish        <= 1'b0;
      timeout       <= 1'b0;
      first_err_idx <= '1;
    end else begin
      prev_wen <= wen;
      if (start) begin
        error_num     <= '0;
        duration      <= '0;
        idx           <= '0;
        finish        <= 1'b0;
        timeout       <= 1'b0;
        first_err_idx <= '1;
      end else if (state == ST_IDLE) begin
        error_num <= '1;
      end else if (state == ST_CHECK) begin
        duration <= duration + 1'b1;
        if (accepted) begin
          idx <= idx + 1'b1;
          if (mismatch) begin
            if (error_num != ERR_SAT) error_num <= error_num + 1'b1;
            // idx never reaches all-ones, so all-ones means "no mismatch yet".
            if (first_err_idx == '1) first_err_idx <= idx;
          end
        end
        if (done) begin
          finish  <= 1'b1;
          timeout <= to_hit;
        end
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mem_result_checker.sv
// -----------------------------------------------------------------------------
// tb_mem_result_checker
//   Directed bench for mem_result_checker. Three instances share the write
//   bus: u_dut (defaults), u_to (TIMEOUT_CYC=50) and u_sat (ERR_W=2).
// -----------------------------------------------------------------------------
module tb_mem_result_checker;
  import mem_checker_pkg::*;

  localparam logic [29:0] TP    = 30'h3FF;
  localparam logic [31:0] BEGIN = 32'h0000_0168;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        gld_wen;
  logic [9:0]  gld_idx;
  logic [31:0] gld_data;

  logic [7:0]  d_err;  logic [15:0] d_dur; logic d_fin, d_to; logic [9:0] d_fei; state_t d_st;
  logic [7:0]  t_err;  logic [15:0] t_dur; logic t_fin, t_to; logic [9:0] t_fei; state_t t_st;
  logic [1:0]  s_err;  logic [15:0] s_dur; logic s_fin, s_to; logic [9:0] s_fei; state_t s_st;

  mem_result_checker u_dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .gld_wen(gld_wen), .gld_idx(gld_idx), .gld_data(gld_data),
    .error_num(d_err), .duration(d_dur), .finish(d_fin), .timeout(d_to),
    .first_err_idx(d_fei), .state_dbg(d_st));

  mem_result_checker #(.TIMEOUT_CYC(50)) u_to (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .gld_wen(gld_wen), .gld_idx(gld_idx), .gld_data(gld_data),
    .error_num(t_err), .duration(t_dur), .finish(t_fin), .timeout(t_to),
    .first_err_idx(t_fei), .state_dbg(t_st));

  mem_result_checker #(.ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .gld_wen(gld_wen), .gld_idx(gld_idx), .gld_data(gld_data),
    .error_num(s_err), .duration(s_dur), .finish(s_fin), .timeout(s_to),
    .first_err_idx(s_fei), .state_dbg(s_st));

  // Golden result table (values as seen after byte swapping).
  logic [31:0] tbl [31] = '{
    32'h0000_0001, 32'h0000_0003, 32'h0000_0007, 32'h0000_000F,
    32'h1234_5678, 32'h8765_4321, 32'hDEAD_BEEF, 32'hCAFE_F00D,
    32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h5555_AAAA, 32'hAAAA_5555,
    32'h0000_0100, 32'h0000_0200, 32'hFFFF_FFFE, 32'h7FFF_FFFF,
    32'h8000_0000, 32'h0102_0304, 32'h0A0B_0C0D, 32'h1111_1111,
    32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h6666_6666,
    32'h7777_7777, 32'h9999_9999, 32'hBBBB_BBBB, 32'hCCCC_CCCC,
    32'hEEEE_EEEE, 32'hFFFF_FF00, 32'hFFFF_FD5D};

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] bus_of(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // One write: wen high for one cycle, then low for one cycle.
  task automatic wr(input logic [29:0] a, input logic [31:0] sd);
    @(negedge clk);
    addr = a; data = bus_of(sd); wen = 1'b1;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic gld(input int i, input logic [31:0] v);
    @(negedge clk);
    gld_idx = 10'(i); gld_data = v; gld_wen = 1'b1;
    @(negedge clk);
    gld_wen = 1'b0;
  endtask

  // Sends all 31 results, either the golden values or their complements.
  task automatic run(input bit inv);
    for (int i = 0; i < 31; i++) exp_q.push_back(inv ? ~tbl[i] : tbl[i]);
    while (exp_q.size() > 0) wr(TP, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    addr = '0; data = '0; wen = 1'b0;
    gld_wen = 1'b0; gld_idx = '0; gld_data = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_err",   32'(d_err), 32'hFF);
    chk("rst_dur",   32'(d_dur), 32'd0);
    chk("rst_fin",   32'(d_fin), 32'd0);
    chk("rst_to",    32'(d_to),  32'd0);
    chk("rst_fei",   32'(d_fei), 32'h3FF);
    chk("rst_state", 32'(d_st),  32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 31; i++) gld(i, tbl[i]);
    chk("idle_err", 32'(d_err), 32'hFF);

    // T1: clean run with one write to a neighbouring address (ignored)
    wr(TP, BEGIN);
    chk("t1_start_state", 32'(d_st), 32'd1);
    for (int i = 0; i < 31; i++) begin
      wr(TP, tbl[i]);
      if (i == 10) wr(30'h3FE, 32'h0);
    end
    chk("t1_fin",   32'(d_fin), 32'd1);
    chk("t1_err",   32'(d_err), 32'd0);
    chk("t1_to",    32'(d_to),  32'd0);
    chk("t1_fei",   32'(d_fei), 32'h3FF);
    chk("t1_dur",   32'(d_dur), 32'd64);
    chk("t1_state", 32'(d_st),  32'd2);

    // T2: entries 5 and 9 corrupted, restarted from REPORT
    gld(5, tbl[5] ^ 32'h1);
    gld(9, tbl[9] ^ 32'h100);
    wr(TP, BEGIN);
    chk("t2_restart_err", 32'(d_err), 32'd0);
    chk("t2_restart_dur", 32'(d_dur), 32'd0);
    chk("t2_restart_fin", 32'(d_fin), 32'd0);
    chk("t2_restart_to",  32'(t_to),  32'd0);
    run(1'b0);
    chk("t2_err", 32'(d_err), 32'd2);
    chk("t2_fei", 32'(d_fei), 32'd5);
    chk("t2_dur", 32'(d_dur), 32'd62);
    chk("t2_fin", 32'(d_fin), 32'd1);
    gld(5, tbl[5]);
    gld(9, tbl[9]);

    // T3: restart clears first_err_idx; golden load during CHECK ignored
    wr(TP, BEGIN);
    chk("t3_fei_clr", 32'(d_fei), 32'h3FF);
    gld(0, 32'h0BAD_0BAD);
    run(1'b0);
    chk("t3_err", 32'(d_err), 32'd0);
    chk("t3_fin", 32'(d_fin), 32'd1);

    // T4: wen held 4 cycles counts as one write
    wr(TP, BEGIN);
    @(negedge clk);
    addr = TP; data = bus_of(tbl[0]); wen = 1'b1;
    repeat (4) @(negedge clk);
    wen = 1'b0;
    for (int i = 1; i < 30; i++) wr(TP, tbl[i]);
    chk("t4_fin_early", 32'(d_fin), 32'd0);
    chk("t4_err_early", 32'(d_err), 32'd0);
    wr(TP, tbl[30]);
    chk("t4_fin", 32'(d_fin), 32'd1);
    chk("t4_err", 32'(d_err), 32'd0);

    // T5: 10 writes then silence; u_to times out at duration 50
    wr(TP, BEGIN);
    for (int i = 0; i < 10; i++) wr(TP, tbl[i]);
    for (int i = 0; i < 200; i++) begin
      if (t_fin) break;
      @(negedge clk);
    end
    chk("t5_fin",  32'(t_fin), 32'd1);
    chk("t5_to",   32'(t_to),  32'd1);
    chk("t5_dur",  32'(t_dur), 32'd50);
    chk("t5_err",  32'(t_err), 32'd0);
    chk("t5_dut_state", 32'(d_st), 32'd1);
    chk("t5_dut_fin",   32'(d_fin), 32'd0);
    repeat (5) @(negedge clk);
    chk("t5_dur_frozen", 32'(t_dur), 32'd50);

    // T6: reset mid-CHECK on u_dut, golden survives reset
    rst = 1'b0;
    #1;
    chk("t6_rst_err",   32'(d_err), 32'hFF);
    chk("t6_rst_state", 32'(d_st),  32'd0);
    chk("t6_rst_fin",   32'(d_fin), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wr(TP, BEGIN);
    run(1'b0);
    chk("t6_err", 32'(d_err), 32'd0);
    chk("t6_fin", 32'(d_fin), 32'd1);

    // T7: all mismatches
    wr(TP, BEGIN);
    run(1'b1);
    chk("t7_err",     32'(d_err), 32'd31);
    chk("t7_fei",     32'(d_fei), 32'd0);
    chk("t7_sat_err", 32'(s_err), 32'd2);
    chk("t7_sat_fin", 32'(s_fin), 32'd1);
    chk("t7_to_err",  32'(t_err), 32'd25);
    chk("t7_to_to",   32'(t_to),  32'd1);

    // T8: reset in the middle of a saturated run on u_sat
    wr(TP, BEGIN);
    for (int i = 0; i < 5; i++) wr(TP, ~tbl[i]);
    chk("t8_sat_err",   32'(s_err), 32'd2);
    chk("t8_sat_state", 32'(s_st),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t8_rst_err",   32'(s_err), 32'd3);
    chk("t8_rst_state", 32'(s_st),  32'd0);
    chk("t8_rst_fin",   32'(s_fin), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t8_post_fin",   32'(s_fin), 32'd0);
    chk("t8_post_state", 32'(s_st),  32'd0);
    chk("t8_post_err",   32'(s_err), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_result_checker.md
MEM_RESULT_CHECKER -- requirements
Module: mem_result_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32, checked data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 30, word-address width.
REQ-003 SHALL have parameter TEST_PORT, default 'h3FF, word address monitored for results.
REQ-004 SHALL have parameter BEGIN_SYM, default 'h00000168, start-of-test marker.
REQ-005 SHALL have parameter NUM_CHECK, default 31, number of result words to compare (1..1023).
REQ-006 SHALL have parameter BYTE_SWAP, default 1, where 1 reverses byte order of data before any comparison.
REQ-007 SHALL have parameter TIMEOUT_CYC, default 16'hFFFF, CHECK-state cycle limit.
REQ-008 SHALL have parameter ERR_W, default 8, error counter width; DUR_W, default 16, duration width.
REQ-009 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-010 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port addr, input, ADDR_W, monitored memory word address.
REQ-012 SHALL have port data, input, DATA_W, monitored write data.
REQ-013 SHALL have port wen, input, 1, monitored write enable.
REQ-014 SHALL have ports gld_wen (1), gld_idx (10), gld_data (DATA_W), all inputs, the golden-value load port.
REQ-015 SHALL have outputs error_num (ERR_W), duration (DUR_W), finish (1), timeout (1), first_err_idx (10).

Function
REQ-016 SHALL define an accepted write as a cycle with wen=1, addr=TEST_PORT and wen=0 in the previous cycle; a held wen SHALL count once.
REQ-017 SHALL compare sdata, which is data byte-swapped when BYTE_SWAP=1 and data unchanged otherwise.
REQ-018 SHALL implement states IDLE, CHECK and REPORT.
REQ-019 IDLE: on an accepted write with sdata=BEGIN_SYM, SHALL go to CHECK next cycle with error_num=0, duration=0 and idx=0; otherwise SHALL hold error_num at all-ones.
REQ-020 CHECK: SHALL increment duration by 1 every cycle.
REQ-021 CHECK: on an accepted write, SHALL compare sdata to golden[idx], then increment idx, and on mismatch increment error_num.
REQ-022 CHECK: an accepted write while idx=NUM_CHECK-1 SHALL be compared and SHALL move the FSM to REPORT next cycle.
REQ-023 CHECK: when duration reaches TIMEOUT_CYC, SHALL move to REPORT and set timeout=1; if this coincides with the final accepted write, that write SHALL still be compared.
REQ-024 REPORT: SHALL hold finish=1 and freeze error_num, duration, timeout and first_err_idx.
REQ-025 REPORT: an accepted BEGIN_SYM write SHALL restart CHECK exactly as in REQ-019 and SHALL clear timeout and first_err_idx.
REQ-026 error_num SHALL saturate at 2^ERR_W-2, since all-ones is reserved for "not started".
REQ-027 first_err_idx SHALL capture idx at the first mismatch of a run and hold it until restart; it SHALL be all-ones when no mismatch has occurred.
REQ-028 golden[gld_idx] SHALL load gld_data on gld_wen in IDLE or REPORT only; loads during CHECK or with gld_idx>=NUM_CHECK SHALL be ignored.
REQ-029 During CHECK, a BEGIN_SYM value written to TEST_PORT SHALL be treated as ordinary result data.
REQ-030 finish and timeout SHALL be registered outputs.

Reset
REQ-031 On rst=0, SHALL set state to IDLE, error_num to all-ones, duration, idx, finish and timeout to 0, first_err_idx to all-ones, and the previous-wen register to 0.
REQ-032 Reset SHALL NOT clear golden storage.
REQ-033 Reset asserted mid-CHECK SHALL abort the run and produce no finish.

Structure
REQ-034 Package mem_checker_pkg SHALL hold the state enum, the default BEGIN_SYM and END_SYM constants, and the byte-swap function.
REQ-035 Golden storage SHALL be a sub-module checker_golden_ram: NUM_CHECK x DATA_W, one synchronous write port, one asynchronous read port.

Verification
REQ-036 Load golden 0..30 with the existing 31-entry table (last entry 'hFFFFFD5D), send BEGIN then 31 matching writes -> finish=1, error_num=0, timeout=0, first_err_idx=1023.
REQ-037 Same run with entries 5 and 9 corrupted -> error_num=2, first_err_idx=5.
REQ-038 Hold wen=1 on TEST_PORT for 4 cycles with matching data -> idx advances by 1 only.
REQ-039 Set TIMEOUT_CYC=50, send BEGIN then 10 writes and stop -> REPORT at duration=50, timeout=1, finish=1.
REQ-040 ERR_W=2 with 31 mismatches -> error_num saturates at 2; assert rst mid-CHECK -> error_num=3, state IDLE, finish=0.
REQ-041 In REPORT, send BEGIN again and rerun -> counters restart from 0; a gld_wen during CHECK leaves golden unchanged.
